spi_rx_sclk_core: RTL and testbench

Soft SPI master receive core.
- Generates SCLK from the system clock with CPOL-selectable idle level.
- Shifts MISO into a receive register on the SPI sample edge and presents each completed byte with a one-cycle valid strobe.
- Sits between the SPI pins and the byte-consumer logic of the soft SPI master. All logic runs in the clk_ext domain; SCLK is a registered output, not a clock.

---
 rtl/spi_rx_pkg.sv | 21 ++
 rtl/spi_rx_sclk_core_sclk_gen.sv | 57 +++++
 rtl/spi_rx_sclk_core.sv | 100 ++++++++++
 tb/tb_spi_rx_sclk_core.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// -----------------------------------------------------------------------------
// spi_rx_pkg
// Shared defaults and width helpers for the soft SPI master receive core.
//   DATA_W_DEF  : default bits per received word
//   CLK_DIV_DEF : default clk_ext cycles per SCLK half-period
//   DIV_CNT_W   : divider counter width for the default CLK_DIV (min 1)
//   BIT_CNT_W   : bit counter width for the default DATA_W (min 1)
//   cnt_w()     : ceil(log2(n)) clamped to at least 1 bit, for per-instance use
// -----------------------------------------------------------------------------
package spi_rx_pkg;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DATA_W_DEF  = 8;
    localparam int CLK_DIV_DEF = 2;
    localparam int DIV_CNT_W   = cnt_w(CLK_DIV_DEF);
    localparam int BIT_CNT_W   = cnt_w(DATA_W_DEF);

endpackage

// File: rtl/spi_rx_sclk_core_sclk_gen.sv
// -----------------------------------------------------------------------------
// sclk_gen
// Divides clk_ext down to SCLK and classifies each SCLK toggle as a leading
// (leaving the CPOL level) or trailing (returning to CPOL) edge.
// Ports:
//   clk_ext   in  system clock, all state on rising edge
//   reset     in  synchronous active-high reset
//   sclk_trig in  1 = run SCLK, 0 = hold SCLK at CPOL
//   CPOL      in  SCLK idle level
//   SCLK      out registered SPI clock
//   lead_stb  out one-cycle strobe: this cycle's toggle makes SCLK != CPOL
//   trail_stb out one-cycle strobe: this cycle's toggle makes SCLK == CPOL
// -----------------------------------------------------------------------------
module sclk_gen
    import spi_rx_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk_ext,
    input  logic reset,
    input  logic sclk_trig,
    input  logic CPOL,
    output logic SCLK,
    output logic lead_stb,
    output logic trail_stb
);

    localparam int DCW = cnt_w(CLK_DIV);

    logic [DCW-1:0] div_cnt;
    logic           div_wrap;
    logic           toggle;

    assign div_wrap = (div_cnt == DCW'(CLK_DIV - 1));
    assign toggle   = !reset && sclk_trig && div_wrap;

    // The new SCLK value after a toggle is ~SCLK; compare it against the
    // current CPOL so a CPOL change reclassifies edges immediately.
    assign lead_stb  = toggle && (SCLK == CPOL);
    assign trail_stb = toggle && (SCLK != CPOL);

    always_ff @(posedge clk_ext) begin
        if (reset) begin
            div_cnt <= '0;
            SCLK    <= CPOL;
        end else if (!sclk_trig) begin
            div_cnt <= '0;
            SCLK    <= CPOL;
        end else if (div_wrap) begin
            div_cnt <= '0;
            SCLK    <= ~SCLK;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_rx_sclk_core.sv
// -----------------------------------------------------------------------------
// spi_rx_sclk_core
// Soft SPI master receive core: generates SCLK and shifts MISO, MSB-first,
// into a receive register on each sample edge, publishing every completed
// word with a one-cycle valid strobe. Everything runs on clk_ext; SCLK is a
// registered output.
// Build option: define SPI_RX_CPHA_EN to add the CPHA input (CPHA=1 samples
// on the trailing edge). Without it sampling is fixed to the leading edge.
// Ports:
//   clk_ext   in  system clock
//   reset     in  synchronous active-high reset
//   sclk_trig in  1 = run SCLK, 0 = idle
//   CPOL      in  SCLK idle level
//   CPHA      in  (SPI_RX_CPHA_EN only) 1 = sample on trailing edge
//   shift     in  1 = capture MISO on sample edges, 0 = hold rx_buffer
//   MISO      in  serial data from slave
//   SCLK      out registered SPI clock
//   rx_buffer out live shift register, newest bit at [0]
//   rx_byte   out last completed word
//   rx_valid  out one-cycle pulse when rx_byte updates
// -----------------------------------------------------------------------------
module spi_rx_sclk_core
    import spi_rx_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic              clk_ext,
    input  logic              reset,
    input  logic              sclk_trig,
    input  logic              CPOL,
`ifdef SPI_RX_CPHA_EN
    input  logic              CPHA,
`endif
    input  logic              shift,
    input  logic              MISO,
    output logic              SCLK,
    output logic [DATA_W-1:0] rx_buffer,
    output logic [DATA_W-1:0] rx_byte,
    output logic              rx_valid
);

    localparam int BCW = cnt_w(DATA_W);

    logic              lead_stb;
    logic              trail_stb;
    logic              sample_stb;
    logic [BCW-1:0]    bit_cnt;
    logic [DATA_W-1:0] shifted;
    logic              word_done;

    sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_ext   (clk_ext),
        .reset     (reset),
        .sclk_trig (sclk_trig),
        .CPOL      (CPOL),
        .SCLK      (SCLK),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb)
    );

`ifdef SPI_RX_CPHA_EN
    assign sample_stb = CPHA ? trail_stb : lead_stb;
`else
    logic unused_trail_stb;
    assign unused_trail_stb = trail_stb;
    assign sample_stb       = lead_stb;
`endif

    assign shifted   = {rx_buffer[DATA_W-2:0], MISO};
    assign word_done = (bit_cnt == BCW'(DATA_W - 1));

    // Sample stage: shift on the sample edge, publish the word on its last bit
    always_ff @(posedge clk_ext) begin
        if (reset) begin
            rx_buffer <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (!sclk_trig) begin
                // A dropped run discards the partial count but keeps the bits.
                bit_cnt <= '0;
            end else if (sample_stb && shift) begin
                rx_buffer <= shifted;
                if (word_done) begin
                    rx_byte  <= shifted;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_sclk_core.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_sclk_core
// Self-checking bench for spi_rx_sclk_core (DATA_W=8, CLK_DIV=2). Expected
// words are queued when the completing bit is driven and popped when the DUT
// raises rx_valid. Define SPI_RX_CPHA_EN to also exercise CPHA=1.
// -----------------------------------------------------------------------------
module tb_spi_rx_sclk_core;

    localparam int DATA_W  = 8;
    localparam int CLK_DIV = 2;

    logic              clk_ext = 1'b0;
    logic              reset;
    logic              sclk_trig;
    logic              CPOL;
`ifdef SPI_RX_CPHA_EN
    logic              CPHA;
`endif
    logic              shift;
    logic              MISO;
    logic              SCLK;
    logic [DATA_W-1:0] rx_buffer;
    logic [DATA_W-1:0] rx_byte;
    logic              rx_valid;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [7:0] sb[$];
    logic [7:0] mdl_acc;
    int         mdl_nb;

    spi_rx_sclk_core #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk_ext   (clk_ext),
        .reset     (reset),
        .sclk_trig (sclk_trig),
        .CPOL      (CPOL),
`ifdef SPI_RX_CPHA_EN
        .CPHA      (CPHA),
`endif
        .shift     (shift),
        .MISO      (MISO),
        .SCLK      (SCLK),
        .rx_buffer (rx_buffer),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid)
    );

    always #10 clk_ext = ~clk_ext;

    // Scoreboard: every rx_valid pulse must match the oldest queued word.
    always @(negedge clk_ext) begin
        logic [7:0] exp_b;
        if (reset === 1'b0 && rx_valid === 1'b1) begin
            chk_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected_valid: rx_byte=%h but no word was expected", rx_byte);
            end else begin
                exp_b = sb.pop_front();
                if (rx_byte !== exp_b)
                    $display("FAIL sb_rx_byte: got %h expected %h", rx_byte, exp_b);
                else
                    pass_cnt++;
            end
        end
    end

    function automatic logic [15:0] msb_seq(input logic [7:0] b);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s[i] = b[7-i];
        return s;
    endfunction

    task automatic drive_bit(input int k, input logic [15:0] ms, input logic [15:0] ss);
        MISO  = ms[k];
        shift = ss[k];
        if (ss[k]) begin
            mdl_acc = {mdl_acc[6:0], ms[k]};
            mdl_nb++;
            if (mdl_nb == 8) begin
                sb.push_back(mdl_acc);
                mdl_nb = 0;
            end
        end
    endtask

    // Starts SCLK from idle and feeds n samples; a sample is recognised when
    // SCLK moves to samp_lvl. valid_at = 1-based sample index of first rx_valid.
    task automatic run_samples(input int n, input logic [15:0] ms, input logic [15:0] ss,
                               input logic samp_lvl, output int valid_at);
        int   k;
        int   budget;
        int   limit;
        logic prev;
        valid_at = 0;
        k        = 0;
        budget   = 0;
        limit    = n * 4 * CLK_DIV + 20;
        mdl_acc  = '0;
        mdl_nb   = 0;
        drive_bit(0, ms, ss);
        prev      = SCLK;
        sclk_trig = 1'b1;
        while (k < n && budget < limit) begin
            @(negedge clk_ext);
            budget++;
            if (SCLK !== prev && SCLK === samp_lvl) begin
                k++;
                if (rx_valid === 1'b1 && valid_at == 0) valid_at = k;
                if (k < n) drive_bit(k, ms, ss);
            end
            prev = SCLK;
        end
        if (k < n) begin
            chk_cnt++;
            $display("FAIL run_timeout: saw %0d sample edges, required %0d", k, n);
        end
    endtask

    task automatic go_idle();
        sclk_trig = 1'b0;
        shift     = 1'b0;
        repeat (2) @(negedge clk_ext);
    endtask

    task automatic test_reset();
        logic stuck;
        reset = 1'b1; CPOL = 1'b1; sclk_trig = 1'b0; shift = 1'b0; MISO = 1'b0;
`ifdef SPI_RX_CPHA_EN
        CPHA = 1'b0;
`endif
        repeat (3) @(negedge clk_ext);
        chk_cnt++; if (SCLK !== 1'b1) $display("FAIL reset_sclk: got %b expected 1", SCLK); else pass_cnt++;
        chk_cnt++; if (rx_buffer !== 8'h00) $display("FAIL reset_rx_buffer: got %h expected 00", rx_buffer); else pass_cnt++;
        chk_cnt++; if (rx_byte !== 8'h00) $display("FAIL reset_rx_byte: got %h expected 00", rx_byte); else pass_cnt++;
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else pass_cnt++;
        reset = 1'b0;
        stuck = 1'b1;
        repeat (10) begin
            @(negedge clk_ext);
            if (SCLK !== 1'b1) stuck = 1'b0;
        end
        chk_cnt++; if (stuck !== 1'b1) $display("FAIL idle_sclk_hold: SCLK left 1 while idle, required 1"); else pass_cnt++;
    endtask

    task automatic test_sclk_period();
        logic exp_s;
        CPOL = 1'b1; shift = 1'b0; sclk_trig = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_ext);
            exp_s = 1'b1 ^ logic'((i / CLK_DIV) & 1);
            chk_cnt++;
            if (SCLK !== exp_s) $display("FAIL sclk_period_c%0d: got %b expected %b", i, SCLK, exp_s);
            else pass_cnt++;
        end
        go_idle();
    endtask

    task automatic test_byte_cpol1();
        int va;
        CPOL = 1'b1;
        run_samples(8, msb_seq(8'hB5), 16'hFFFF, 1'b0, va);
        chk_cnt++; if (va != 8) $display("FAIL byte_valid_edge: valid at sample %0d expected 8", va); else pass_cnt++;
        chk_cnt++; if (rx_byte !== 8'hB5) $display("FAIL byte_rx_byte: got %h expected b5", rx_byte); else pass_cnt++;
        chk_cnt++; if (rx_buffer !== 8'hB5) $display("FAIL byte_rx_buffer: got %h expected b5", rx_buffer); else pass_cnt++;
        @(negedge clk_ext);
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL byte_valid_width: got %b expected 0", rx_valid); else pass_cnt++;
        go_idle();
    endtask

    task automatic test_shift_gate();
        int va;
        CPOL = 1'b1;
        // samples 3 and 4 carry zeros with shift=0; they must not be captured
        run_samples(10, 16'h02B1, 16'h03F3, 1'b0, va);
        chk_cnt++; if (va != 10) $display("FAIL gate_valid_edge: valid at sample %0d expected 10", va); else pass_cnt++;
        chk_cnt++; if (rx_byte !== 8'hB5) $display("FAIL gate_rx_byte: got %h expected b5", rx_byte); else pass_cnt++;
        go_idle();
    endtask

    task automatic test_trig_drop();
        int va;
        CPOL = 1'b1;
        run_samples(5, msb_seq(8'hB5), 16'hFFFF, 1'b0, va);
        sclk_trig = 1'b0;
        shift     = 1'b0;
        @(negedge clk_ext);
        chk_cnt++; if (SCLK !== 1'b1) $display("FAIL drop_sclk_idle: got %b expected 1", SCLK); else pass_cnt++;
        chk_cnt++; if (va != 0) $display("FAIL drop_no_valid: valid at sample %0d expected none", va); else pass_cnt++;
        chk_cnt++; if (rx_buffer !== 8'hB6) $display("FAIL drop_partial_buf: got %h expected b6", rx_buffer); else pass_cnt++;
        @(negedge clk_ext);
        run_samples(8, msb_seq(8'h3C), 16'hFFFF, 1'b0, va);
        chk_cnt++; if (va != 8) $display("FAIL restart_valid_edge: valid at sample %0d expected 8", va); else pass_cnt++;
        chk_cnt++; if (rx_byte !== 8'h3C) $display("FAIL restart_rx_byte: got %h expected 3c", rx_byte); else pass_cnt++;
        go_idle();
    endtask

    task automatic test_reset_midword();
        int va;
        CPOL = 1'b0;
        repeat (2) @(negedge clk_ext);
        run_samples(3, msb_seq(8'hFF), 16'hFFFF, 1'b1, va);
        reset = 1'b1;
        @(negedge clk_ext);
        chk_cnt++; if (SCLK !== 1'b0) $display("FAIL rst_mid_sclk: got %b expected 0", SCLK); else pass_cnt++;
        chk_cnt++; if (rx_buffer !== 8'h00) $display("FAIL rst_mid_buf: got %h expected 00", rx_buffer); else pass_cnt++;
        chk_cnt++; if (rx_byte !== 8'h00) $display("FAIL rst_mid_byte: got %h expected 00", rx_byte); else pass_cnt++;
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", rx_valid); else pass_cnt++;
        reset     = 1'b0;
        sclk_trig = 1'b0;
        shift     = 1'b0;
        repeat (2) @(negedge clk_ext);
        run_samples(8, msb_seq(8'h5A), 16'hFFFF, 1'b1, va);
        chk_cnt++; if (va != 8) $display("FAIL rst_mid_bitcnt: valid at sample %0d expected 8", va); else pass_cnt++;
        chk_cnt++; if (rx_byte !== 8'h5A) $display("FAIL cpol0_rx_byte: got %h expected 5a", rx_byte); else pass_cnt++;
        go_idle();
    endtask

`ifdef SPI_RX_CPHA_EN
    task automatic test_cpha();
        int va;
        CPOL = 1'b0;
        CPHA = 1'b1;
        repeat (2) @(negedge clk_ext);
        run_samples(8, msb_seq(8'hB5), 16'hFFFF, 1'b0, va);
        chk_cnt++; if (va != 8) $display("FAIL cpha_valid_edge: valid at sample %0d expected 8", va); else pass_cnt++;
        chk_cnt++; if (rx_byte !== 8'hB5) $display("FAIL cpha_rx_byte: got %h expected b5", rx_byte); else pass_cnt++;
        go_idle();
        CPHA = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sclk_period();
        test_byte_cpol1();
        test_shift_gate();
        test_trig_drop();
        test_reset_midword();
`ifdef SPI_RX_CPHA_EN
        test_cpha();
`endif
        repeat (4) @(negedge clk_ext);
        chk_cnt++;
        if (sb.size() != 0) $display("FAIL sb_drain: %0d words still expected, required 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
